bec_key_sequencer: RTL and testbench
====================================

// Module: bec_key_sequencer
// PURPOSE
// Host-side driver of the BEC ladder-step controller's key/iteration interface. Latches a
// KEY_W-bit scalar and holds core_enable high for the whole run. Presents one key bit on
// core_ki per ladder iteration, MSB first, and advances on each core_next_key pulse.
// Captures core_wout/core_zout on core_done and holds them for the host until acknowledged.
// Includes a per-iteration watchdog and a protocol-error check.
// PARAMETERS
// KEY_W           163   scalar width = number of ladder iterations
// TIMEOUT_CYCLES  4096  max cycles between consecutive core_next_key pulses before abort
// CNT_W           8     width of bit_index (must hold KEY_W-1)
// PORTS
// clk            in   1      clock
// rst_n          in   1      synchronous reset, active low
// start          in   1      1-cycle request; accepted only in IDLE
// key            in   KEY_W  scalar; sampled on accepted start
// busy           out  1      high in RUN and DRAIN
// bit_index      out  CNT_W  index of the iteration currently presented (0 = key[KEY_W-1])
// result_valid   out  1      w_result/z_result valid; held until result_ack
// result_ack     in   1      host consumes result
// w_result       out  KEY_W  captured core_wout
// z_result       out  KEY_W  captured core_zout
// err            out  1      timeout or protocol error; sticky until next accepted start
// core_enable    out  1      enable to step controller; its iteration counter clears when low
// core_ki        out  1      current key bit
// core_next_key  in   1      1-cycle pulse at end of each iteration
// core_done      in   1      1-cycle pulse with final outputs; coincides with last core_next_key
// core_wout      in   KEY_W  final W; sampled only when core_done=1
// core_zout      in   KEY_W  final Z; sampled only when core_done=1
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): state=IDLE. All outputs are 0: busy, bit_index, result_valid,
//   w_result, z_result, err, core_enable, core_ki. Shift register and watchdog are cleared.
// - Reset mid-run aborts immediately; no result is produced.
// - FSM: IDLE -> RUN -> DRAIN -> HOLD -> IDLE.
// - An error from RUN goes to ERR, which behaves as IDLE with err=1.
// - IDLE/ERR + start:
//   - next cycle: key_sr=key, bit_index=0, err=0, core_enable=1, core_ki=key[KEY_W-1], state=RUN.
// - RUN + core_next_key with core_done=0:
//   - if bit_index==KEY_W-1: protocol error -> ERR.
//   - else next cycle: key_sr shifts left by 1, bit_index+1, core_ki=new MSB, watchdog=0.
//   - core_ki changes only in the cycle after a pulse; it is stable for the whole iteration.
// - RUN + core_done:
//   - if bit_index==KEY_W-1: next cycle w_result/z_result <= core_wout/core_zout,
//     core_enable=0, state=DRAIN.
//   - if bit_index<KEY_W-1: protocol error -> ERR; w_result/z_result are not updated.
// - DRAIN: one cycle with core_enable=0, which clears the core iteration counter.
//   Next cycle: result_valid=1, state=HOLD.
// - HOLD: result_valid and results stay stable.
//   - result_ack -> next cycle result_valid=0, state=IDLE.
//   - w_result/z_result keep their values until the next capture.
// - Watchdog: counts RUN cycles since the last pulse, or since RUN entry.
//   - count==TIMEOUT_CYCLES-1 with no pulse -> next cycle err=1, core_enable=0, state=ERR.
// - On ERR entry: core_enable=0, core_ki=0, bit_index holds the failing index.
// - start is ignored in RUN, DRAIN and HOLD. result_ack outside HOLD is ignored.
// - Latency: start to core_enable = 1 cycle. core_done to result_valid = 2 cycles.
// CONFIGURATION
// - BEC_CYCLE_COUNT_EN defined:
//   - adds output cycle_count [31:0]: cleared on accepted start, +1 each RUN cycle,
//     saturates at 2^32-1, frozen outside RUN, 0 on reset.
// - Not defined: port and counter are absent; all other behaviour is identical.
// TESTING
// 1. key=all ones; core model pulses next_key every 20 cycles, done on pulse 163
//    -> core_ki=1 for all 163 iterations; result_valid 2 cycles after done; results match model.
// 2. key=163'h1 -> core_ki=0 for bit_index 0..161 and 1 at bit_index 162;
//    bit_index increments once per pulse.
// 3. TIMEOUT_CYCLES=64; model stops after 5 pulses
//    -> err=1 and core_enable=0 exactly 64 cycles after the last pulse; bit_index=5.
// 4. Model raises core_done with next_key at bit_index=10
//    -> ERR; err=1; w_result/z_result unchanged; a following start clears err.
// 5. rst_n=0 at bit_index=50 -> next cycle all outputs 0; a following start runs cleanly.
// 6. start pulses during RUN and HOLD are ignored; result_ack held 3 cycles late
//    -> result_valid drops 1 cycle after ack; a new start is accepted only afterwards.

Source files
------------

// File: rtl/bec_key_sequencer.sv
// Host-side key/iteration driver for the BEC ladder-step controller: feeds key bits MSB first,
// captures the final W/Z, and aborts on watchdog timeout or protocol error.
// Optional `BEC_CYCLE_COUNT_EN adds a saturating RUN-cycle counter output (cycle_count).
module bec_key_sequencer #(
  parameter int KEY_W          = 163,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  output logic             busy,
  output logic [CNT_W-1:0] bit_index,
  output logic             result_valid,
  input  logic             result_ack,
  output logic [KEY_W-1:0] w_result,
  output logic [KEY_W-1:0] z_result,
  output logic             err,
  output logic             core_enable,
  output logic             core_ki,
  input  logic             core_next_key,
  input  logic             core_done,
  input  logic [KEY_W-1:0] core_wout,
  input  logic [KEY_W-1:0] core_zout
`ifdef BEC_CYCLE_COUNT_EN
  ,
  output logic [31:0]      cycle_count
`endif
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KEY_W - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_HOLD  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_sr_q, key_sr_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [KEY_W-1:0] w_q, w_d;
  logic [KEY_W-1:0] z_q, z_d;

  logic last_iter;
  assign last_iter = (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      key_sr_q <= '0;
      idx_q    <= '0;
      wd_q     <= '0;
      w_q      <= '0;
      z_q      <= '0;
    end else begin
      state_q  <= state_d;
      key_sr_q <= key_sr_d;
      idx_q    <= idx_d;
      wd_q     <= wd_d;
      w_q      <= w_d;
      z_q      <= z_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    key_sr_d = key_sr_q;
    idx_d    = idx_q;
    wd_d     = wd_q;
    w_d      = w_q;
    z_d      = z_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          key_sr_d = key;
          idx_d    = '0;
          wd_d     = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // core_done is checked first: it arrives together with the final next_key pulse
        if (core_done) begin
          if (last_iter) begin
            w_d     = core_wout;
            z_d     = core_zout;
            state_d = S_DRAIN;
          end else begin
            state_d = S_ERR;
          end
        end else if (core_next_key) begin
          if (last_iter) begin
            state_d = S_ERR;
          end else begin
            key_sr_d = {key_sr_q[KEY_W-2:0], 1'b0};
            idx_d    = idx_q + CNT_W'(1);
            wd_d     = '0;
          end
        end else if (wd_q == WD_MAX) begin
          state_d = S_ERR;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_DRAIN: state_d = S_HOLD;
      S_HOLD: begin
        if (result_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from state, so ERR/DRAIN force core_enable and core_ki low
  assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign core_enable  = (state_q == S_RUN);
  assign core_ki      = (state_q == S_RUN) && key_sr_q[KEY_W-1];
  assign err          = (state_q == S_ERR);
  assign result_valid = (state_q == S_HOLD);
  assign bit_index    = idx_q;
  assign w_result     = w_q;
  assign z_result     = z_q;

`ifdef BEC_CYCLE_COUNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_ff @(posedge clk) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

  always_comb begin
    cyc_d = cyc_q;
    if ((state_q == S_IDLE || state_q == S_ERR) && start) cyc_d = '0;
    else if (state_q == S_RUN && cyc_q != 32'hFFFF_FFFF) cyc_d = cyc_q + 32'd1;
  end

  assign cycle_count = cyc_q;
`endif

endmodule

// File: tb/tb_bec_key_sequencer.sv
// Randomized scoreboard bench for bec_key_sequencer: a core model drives next_key/done,
// expected key bits and results are queued at stimulus time and checked by a monitor.
module tb_bec_key_sequencer;
  localparam int KEY_W = 163;
  localparam int TO    = 64;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [KEY_W-1:0] key = '0;
  logic             busy;
  logic [CNT_W-1:0] bit_index;
  logic             result_valid;
  logic             result_ack = 1'b0;
  logic [KEY_W-1:0] w_result, z_result;
  logic             err, core_enable, core_ki;
  logic             core_next_key = 1'b0;
  logic             core_done = 1'b0;
  logic [KEY_W-1:0] core_wout = '0;
  logic [KEY_W-1:0] core_zout = '0;
`ifdef BEC_CYCLE_COUNT_EN
  logic [31:0]      cycle_count;
`endif

  bec_key_sequencer #(.KEY_W(KEY_W), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .busy(busy),
    .bit_index(bit_index), .result_valid(result_valid), .result_ack(result_ack),
    .w_result(w_result), .z_result(z_result), .err(err), .core_enable(core_enable),
    .core_ki(core_ki), .core_next_key(core_next_key), .core_done(core_done),
    .core_wout(core_wout), .core_zout(core_zout)
`ifdef BEC_CYCLE_COUNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct { int idx; logic ki; } ki_t;
  typedef struct { logic [KEY_W-1:0] w; logic [KEY_W-1:0] z; } res_t;
  ki_t  ki_q[$];
  res_t res_q[$];
  logic [KEY_W-1:0] last_w = '0;
  logic [KEY_W-1:0] last_z = '0;

  function automatic void chk(input string name, input logic [KEY_W-1:0] act,
                              input logic [KEY_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [KEY_W-1:0] rand_key();
    logic [KEY_W-1:0] r = '0;
    for (int i = 0; i < 6; i++) r = {r[KEY_W-33:0], 32'($urandom())};
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops expected key bits at each accepted pulse and results on result_valid rise
  initial begin : monitor
    ki_t  e_ki;
    res_t e_res;
    int   done_cyc = 0;
    logic rv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (core_enable && core_next_key) begin
        if (ki_q.size() == 0) begin
          chk("unexpected_pulse_check", 1, 0);
        end else begin
          e_ki = ki_q.pop_front();
          chk("bit_index_at_pulse", bit_index, e_ki.idx);
          chk("core_ki_at_pulse", core_ki, e_ki.ki);
        end
      end
      if (core_enable && core_done) done_cyc = cyc;
      if (result_valid && !rv_prev) begin
        if (res_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e_res = res_q.pop_front();
          chk("w_result", w_result, e_res.w);
          chk("z_result", z_result, e_res.z);
          chk("done_to_valid_latency", cyc - done_cyc, 2);
        end
      end
      rv_prev = result_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [KEY_W-1:0] k);
    key   = k;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_core_enable", core_enable, 1);
    chk("start_bit_index", bit_index, 0);
    chk("start_err_clear", err, 0);
    chk("start_core_ki", core_ki, k[KEY_W-1]);
  endtask

  // Core model: n pulses, one every `period` cycles; done rides on pulse number done_at
  task automatic run_pulses(input logic [KEY_W-1:0] k, input int n, input int period,
                            input int done_at, input bit poke_start);
    for (int p = 0; p < n; p++) begin
      repeat (period - 1) tick();
      ki_q.push_back('{idx: p, ki: k[KEY_W-1-p]});
      core_next_key = 1'b1;
      if (poke_start && p == n / 2) begin
        start = 1'b1;
        key   = ~k;
      end
      if (p + 1 == done_at) begin
        core_done = 1'b1;
        core_wout = rand_key();
        core_zout = rand_key();
        if (p == KEY_W - 1) begin
          res_q.push_back('{w: core_wout, z: core_zout});
          last_w = core_wout;
          last_z = core_zout;
        end
      end
      tick();
      core_next_key = 1'b0;
      core_done     = 1'b0;
      start         = 1'b0;
    end
  endtask

  task automatic finish_result(input int late, input bit poke_start);
    int k = 0;
    while (!result_valid && k < 10) begin
      tick();
      k++;
    end
    chk("result_valid_seen", result_valid, 1);
    repeat (late) tick();
    if (poke_start) begin
      start = 1'b1;
      key   = rand_key();
      tick();
      start = 1'b0;
      chk("hold_ignores_start_busy", busy, 0);
      chk("hold_ignores_start_rv", result_valid, 1);
    end
    chk("hold_w_stable", w_result, last_w);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk("rv_drop_after_ack", result_valid, 0);
    chk("idle_after_ack_busy", busy, 0);
    chk("w_kept_after_ack", w_result, last_w);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_bit_index"}, bit_index, 0);
    chk({tag, "_result_valid"}, result_valid, 0);
    chk({tag, "_w_result"}, w_result, 0);
    chk({tag, "_z_result"}, z_result, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_core_enable"}, core_enable, 0);
    chk({tag, "_core_ki"}, core_ki, 0);
  endtask

  initial begin : stim
    logic [KEY_W-1:0] k;
    int t;
    repeat (3) tick();
    chk_all_zero("reset");
`ifdef BEC_CYCLE_COUNT_EN
    chk("reset_cycle_count", cycle_count, 0);
`endif
    rst_n = 1'b1;
    tick();

    // All-ones key, 20-cycle iterations
    k = '1;
    do_start(k);
    run_pulses(k, KEY_W, 20, KEY_W, 1'b0);
`ifdef BEC_CYCLE_COUNT_EN
    chk("cycle_count_run", cycle_count, KEY_W * 20);
`endif
    finish_result(1, 1'b0);

    // Single low bit: only the last iteration presents 1; late ack with start poked in HOLD
    k = '0;
    k[0] = 1'b1;
    do_start(k);
    run_pulses(k, KEY_W, 2, KEY_W, 1'b1);
    finish_result(3, 1'b1);

    // Watchdog after 5 pulses
    k = rand_key();
    do_start(k);
    run_pulses(k, 5, 7, 0, 1'b0);
    t = 0;
    while (!err && t < 200) begin
      tick();
      t++;
    end
    chk("timeout_cycles", t, TO);
    chk("timeout_core_enable", core_enable, 0);
    chk("timeout_bit_index", bit_index, 5);
    chk("timeout_core_ki", core_ki, 0);

    // Early core_done at bit_index 10
    k = rand_key();
    do_start(k);
    run_pulses(k, 11, 3, 11, 1'b0);
    chk("early_done_err", err, 1);
    chk("early_done_core_enable", core_enable, 0);
    chk("early_done_bit_index", bit_index, 10);
    chk("early_done_w_kept", w_result, last_w);
    chk("early_done_z_kept", z_result, last_z);

    // Reset mid-run at bit_index 50
    k = rand_key();
    do_start(k);
    run_pulses(k, 50, 3, 0, 1'b1);
    chk("pre_reset_bit_index", bit_index, 50);
    rst_n = 1'b0;
    tick();
    chk_all_zero("midrun_reset");
    rst_n = 1'b1;
    last_w = '0;
    last_z = '0;
    tick();

    // Random clean runs
    for (int r = 0; r < 3; r++) begin
      k = rand_key();
      do_start(k);
      run_pulses(k, KEY_W, int'($urandom_range(2, 5)), KEY_W, r[0]);
      finish_result(int'($urandom_range(0, 4)), 1'b0);
    end

    repeat (3) tick();
    chk("ki_queue_drained", ki_q.size(), 0);
    chk("result_queue_drained", res_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end
endmodule
